// File: rtl/spi_master_byte.sv
// spi_master_byte: mode-0 SPI master, one MSB-first byte per start/ready handshake.
//   clk, nrst      system clock, synchronous active-low reset
//   div            sclk half-period minus one (clk cycles), latched at accept
//   start/ready    transfer request / idle-and-accepting
//   tx_data        byte to send, latched at accept
//   cs_sel         chip-select index, latched at accept (>= NUM_CS gives dummy clocks)
//   cs_hold        keep ncs asserted after this byte
//   cs_release     drop a held ncs while idle
//   rx_valid       one-cycle strobe with rx_data = received byte
//   sclk/mosi/miso SPI bus, sclk idles low; ncs active-low per slave
module spi_master_byte #(
    parameter int NUM_CS    = 4,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 start,
    input  logic [7:0]           tx_data,
    input  logic [2:0]           cs_sel,
    input  logic                 cs_hold,
    input  logic                 cs_release,
    output logic                 ready,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    output logic                 sclk,
    output logic [NUM_CS-1:0]    ncs,
    output logic                 mosi,
    input  logic                 miso
);

    typedef enum logic [1:0] {IDLE, GAP, SHIFT, DONE} state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [3:0]            phase_q, phase_d;
    logic [7:0]            tx_q, tx_d;
    logic [7:0]            rx_q, rx_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic [2:0]            cs_q, cs_d;
    logic [2:0]            held_cs_q, held_cs_d;
    logic                  hold_q, hold_d;
    logic                  held_q, held_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [NUM_CS-1:0]     ncs_q, ncs_d;
    logic [NUM_CS-1:0]     sel_ncs;
    logic [2:0]            cs_next;
    logic                  accept;
    logic                  phase_end;

    assign ready     = (state_q == IDLE) || (state_q == DONE);
    assign accept    = ready && start;
    assign phase_end = (cnt_q == div_q);
    assign cs_next   = accept ? cs_sel : cs_q;

    // One-cold decode; out-of-range indices leave every select high.
    always_comb begin
        sel_ncs = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (cs_next == 3'(i)) sel_ncs[i] = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        cs_d       = cs_q;
        held_cs_d  = held_cs_q;
        hold_d     = hold_q;
        held_d     = held_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ncs_d      = ncs_q;
        rx_valid_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    div_d   = div;
                    cs_d    = cs_sel;
                    hold_d  = cs_hold;
                    cnt_d   = '0;
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    // Switching away from a held slave needs an all-high gap first.
                    if (held_q && held_cs_q != cs_sel) begin
                        state_d = GAP;
                        ncs_d   = '1;
                        mosi_d  = 1'b0;
                        tx_d    = tx_data;
                    end else begin
                        state_d = SHIFT;
                        ncs_d   = sel_ncs;
                        mosi_d  = tx_data[7];
                        tx_d    = {tx_data[6:0], 1'b0};
                    end
                end else if (state_q == IDLE && cs_release && held_q) begin
                    ncs_d  = '1;
                    held_d = 1'b0;
                end
            end
            GAP: begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
                if (phase_end) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    phase_d = '0;
                    ncs_d   = sel_ncs;
                    mosi_d  = tx_q[7];
                    tx_d    = {tx_q[6:0], 1'b0};
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
                if (phase_end) begin
                    cnt_d   = '0;
                    phase_d = phase_q + 4'd1;
                    // Even phases are low; their end is the rising edge where miso is taken.
                    if (!phase_q[0]) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso};
                    end else if (phase_q != 4'd15) begin
                        sclk_d = 1'b0;
                        mosi_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end else begin
                        state_d    = DONE;
                        sclk_d     = 1'b0;
                        mosi_d     = 1'b0;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_q;
                        held_d     = hold_q;
                        held_cs_d  = cs_q;
                        if (!hold_q) ncs_d = '1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            phase_q    <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            cs_q       <= '0;
            held_cs_q  <= '0;
            hold_q     <= 1'b0;
            held_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ncs_q      <= '1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            cs_q       <= cs_d;
            held_cs_q  <= held_cs_d;
            hold_q     <= hold_d;
            held_q     <= held_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            ncs_q      <= ncs_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ncs      = ncs_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte: vector table plus random transfers against an SPI slave/timing model.
module tb_spi_master_byte;

    logic       clk = 1'b0;
    logic       nrst, start, cs_hold, cs_release, miso;
    logic [7:0] div, tx_data;
    logic [2:0] cs_sel;
    logic       ready, rx_valid, sclk, mosi;
    logic [7:0] rx_data;
    logic [3:0] ncs;

    int passed = 0;
    int total  = 0;

    spi_master_byte dut (
        .clk(clk), .nrst(nrst), .div(div), .start(start), .tx_data(tx_data),
        .cs_sel(cs_sel), .cs_hold(cs_hold), .cs_release(cs_release),
        .ready(ready), .rx_valid(rx_valid), .rx_data(rx_data), .sclk(sclk),
        .ncs(ncs), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         dv;
        logic [7:0] tx;
        logic [2:0] cs;
        bit         hold;
        bit         b2b;
        bit         extra;
        logic [7:0] sb;
        int         lat;
        bit         gap;
        logic [7:0] rx;
        logic [3:0] ncs_done;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    function automatic logic [3:0] dec(input logic [2:0] c);
        return (c < 3'd4) ? ~(4'b0001 << c) : 4'hF;
    endfunction

    // Slave drives v.sb MSB first, changing miso after each sclk fall, and
    // collects mosi at each rise; phase edges are checked against their ideal cycle.
    task automatic xfer(input vec_t v);
        int h = v.dv + 1;
        int g = v.gap ? h : 0;
        int n = 0, rises = 0, falls = 0, idx = 0;
        bit done = 0, tbad = 0, nbad = 0, psclk;
        logic [7:0] mbits = '0;
        logic [3:0] ex = dec(v.cs);
        div = 8'(v.dv); tx_data = v.tx; cs_sel = v.cs; cs_hold = v.hold;
        start = 1'b1; miso = v.sb[7];
        psclk = sclk;
        while (!done && n < 4000) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin start = 1'b0; chk("ready_drop", ready, 0); end
            if (v.extra && n == 3) begin start = 1'b1; tx_data = ~v.tx; cs_sel = 3'd2; div = 8'd0; end
            if (v.extra && n == 4) start = 1'b0;
            if (rx_valid) done = 1;
            else begin
                if (sclk && !psclk) begin
                    if (n != g + h * (2 * rises + 1) + 1) tbad = 1;
                    rises++;
                    mbits = {mbits[6:0], mosi};
                end
                if (!sclk && psclk) begin
                    if (n != g + h * (2 * falls + 2) + 1) tbad = 1;
                    falls++;
                    idx++;
                    if (idx < 8) miso = v.sb[7 - idx];
                end
                if (ncs !== ((n <= g) ? 4'hF : ex)) nbad = 1;
            end
            psclk = sclk;
        end
        chk("done_seen", done, 1);
        chk("latency", n, v.lat);
        chk("rx_data", rx_data, v.rx);
        chk("mosi_bits", mbits, v.tx);
        chk("sclk_rises", rises, 8);
        chk("sclk_timing", tbad, 0);
        chk("ncs_during", nbad, 0);
        chk("ncs_done", ncs, v.ncs_done);
        chk("ready_done", ready, 1);
        chk("lines_done", {sclk, mosi}, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hc = -1;
        int rv;
        nrst = 1'b0; start = 1'b0; cs_hold = 1'b0; cs_release = 1'b0; miso = 1'b0;
        div = '0; tx_data = '0; cs_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_sclk_mosi", {sclk, mosi}, 0);
        chk("rst_ncs", ncs, 4'hF);
        nrst = 1'b1;
        idle(2);

        vq.push_back(vec_t'{0, 8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 17, 1'b0, 8'h3C, 4'hF});
        vq.push_back(vec_t'{3, 8'h81, 3'd0, 1'b0, 1'b0, 1'b0, 8'h7E, 65, 1'b0, 8'h7E, 4'hF});
        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v.dv = $urandom_range(0, 3);
            v.tx = 8'($urandom);
            v.cs = 3'($urandom_range(0, 7));
            v.hold = (v.cs < 3'd4) ? 1'($urandom) : 1'b0;
            v.b2b = 1'($urandom);
            v.extra = 1'b0;
            v.sb = 8'($urandom);
            v.gap = (hc >= 0) && (hc != int'(v.cs));
            v.lat = 1 + 16 * (v.dv + 1) + (v.gap ? v.dv + 1 : 0);
            v.rx = v.sb;
            v.ncs_done = v.hold ? dec(v.cs) : 4'hF;
            hc = v.hold ? int'(v.cs) : -1;
            vq.push_back(v);
        end
        foreach (vq[i]) begin
            if (!vq[i].b2b) idle(2);
            xfer(vq[i]);
        end
        idle(1);
        cs_release = 1'b1; idle(1); cs_release = 1'b0;

        // Held cs 1 across two back-to-back bytes, then released while idle.
        idle(2);
        xfer(vec_t'{0, 8'h11, 3'd1, 1'b1, 1'b0, 1'b0, 8'hC3, 17, 1'b0, 8'hC3, 4'hD});
        xfer(vec_t'{0, 8'h22, 3'd1, 1'b1, 1'b1, 1'b0, 8'h5A, 17, 1'b0, 8'h5A, 4'hD});
        idle(3);
        chk("ncs_held_idle", ncs, 4'hD);
        cs_release = 1'b1; idle(1); cs_release = 1'b0;
        chk("ncs_release", ncs, 4'hF);

        // Held cs 1, then cs 2 with div=1: two-cycle all-high gap.
        idle(2);
        xfer(vec_t'{0, 8'h33, 3'd1, 1'b1, 1'b0, 1'b0, 8'h0F, 17, 1'b0, 8'h0F, 4'hD});
        idle(1);
        xfer(vec_t'{1, 8'h44, 3'd2, 1'b0, 1'b0, 1'b0, 8'h99, 35, 1'b1, 8'h99, 4'hF});

        // Starts while busy are dropped: one rx_valid, data unchanged.
        idle(2);
        xfer(vec_t'{1, 8'h96, 3'd0, 1'b0, 1'b0, 1'b1, 8'h6B, 33, 1'b0, 8'h6B, 4'hF});
        rv = 0;
        repeat (6) begin @(posedge clk); #1; if (rx_valid) rv++; end
        chk("single_rx_valid", rv, 0);
        chk("ready_after", ready, 1);

        // Out-of-range select: dummy clocks with every ncs high.
        xfer(vec_t'{0, 8'h5C, 3'd7, 1'b0, 1'b0, 1'b0, 8'hE1, 17, 1'b0, 8'hE1, 4'hF});

        // Reset at the 5th edge of a transfer to a held slave.
        idle(2);
        xfer(vec_t'{0, 8'h0F, 3'd1, 1'b1, 1'b0, 1'b0, 8'h77, 17, 1'b0, 8'h77, 4'hD});
        idle(1);
        div = 8'd0; tx_data = 8'hAA; cs_sel = 3'd1; cs_hold = 1'b0; start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(3);
        nrst = 1'b0;
        idle(1);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_ncs", ncs, 4'hF);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_mosi", mosi, 0);
        nrst = 1'b1;
        idle(1);
        xfer(vec_t'{0, 8'h3C, 3'd2, 1'b0, 1'b0, 1'b0, 8'h18, 17, 1'b0, 8'h18, 4'hF});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
